// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : two-port (CPU data / loader) arbiter onto one word-wide RAM
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              a_req,
  input  logic              a_we,
  input  logic [31:0]       a_addr,
  input  logic [31:0]       a_wdata,
  input  logic [3:0]        a_wstrb,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [31:0]       a_rdata,

  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [31:0]       b_wdata,
  input  logic [3:0]        b_wstrb,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [31:0]       b_rdata,

  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,

  output logic              addr_err
);

  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic             pend_valid;
  logic             pend_owner;     // 0 = port A, 1 = port B
  logic             pend_in_range;

  logic             a_win;
  logic             b_win;
  logic             any_win;
  logic             sel_we;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [3:0]       sel_wstrb;
  logic             in_range;
  logic [31:0]      read_data;
  logic             unused_addr_lsbs;

  // B only beats a competing A once it has been starved for STARVE_LIMIT cycles
  assign b_win   = !reset && b_req && (!a_req || (starve_cnt == LIMIT));
  assign a_win   = !reset && a_req && !b_win;
  assign any_win = a_win || b_win;

  assign sel_we    = b_win ? b_we    : a_we;
  assign sel_addr  = b_win ? b_addr  : a_addr;
  assign sel_wdata = b_win ? b_wdata : a_wdata;
  assign sel_wstrb = b_win ? b_wstrb : a_wstrb;
  assign in_range  = (sel_addr[31:ADDR_W+2] == '0);

  assign unused_addr_lsbs = ^sel_addr[1:0];

  assign a_gnt     = a_win;
  assign b_gnt     = b_win;
  assign ram_en    = any_win && in_range;
  assign ram_we    = (ram_en && sel_we) ? sel_wstrb : 4'b0000;
  assign ram_addr  = any_win ? sel_addr[ADDR_W+1:2] : '0;
  assign ram_wdata = any_win ? sel_wdata : 32'h0;
  assign addr_err  = any_win && !in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt    <= '0;
      pend_valid    <= 1'b0;
      pend_owner    <= 1'b0;
      pend_in_range <= 1'b0;
    end else begin
      if (b_req && !b_win) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
      pend_valid    <= any_win && !sel_we;
      pend_owner    <= b_win;
      pend_in_range <= in_range;
    end
  end

  // Out-of-range reads still complete, but return zero instead of RAM data
  assign read_data = pend_in_range ? ram_rdata : 32'h0;

  assign a_rvalid = pend_valid && !pend_owner;
  assign b_rvalid = pend_valid &&  pend_owner;
  assign a_rdata  = a_rvalid ? read_data : 32'h0;
  assign b_rdata  = b_rvalid ? read_data : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : table-driven check of mem_arbiter against a small RAM model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  localparam int OBS_W = 118;
  localparam logic [31:0] D0 = 32'hDEADBEEF;
  localparam logic [31:0] D5 = 32'hCAFEF00D;
  localparam logic [31:0] D7 = 32'h0BADC0DE;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [3:0]  a_wstrb, b_wstrb;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        ram_en, addr_err;
  logic [3:0]  ram_we;
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata;

  int applied = 0;
  int miscompares = 0;

  mem_arbiter #(.ADDR_W(12), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_wstrb(a_wstrb),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_wstrb(b_wstrb),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model: one-cycle read, byte-enabled write, preloaded in reset
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (reset) begin
      mem[2] <= 32'h0;
      mem[4] <= D0;
      mem[5] <= D5;
      mem[7] <= D7;
      ram_rdata <= 32'h0;
    end else if (ram_en) begin
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
    end
  end

  logic [OBS_W-1:0] act;
  assign act = {a_gnt, b_gnt, ram_en, ram_we, ram_addr, ram_wdata, addr_err,
                a_rvalid, a_rdata, b_rvalid, b_rdata};

  typedef struct {
    logic        a_req, a_we;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_wstrb;
    logic        b_req, b_we;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_wstrb;
    logic [OBS_W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [OBS_W-1:0] expv(
      input logic ag, input logic bg, input logic en, input logic [3:0] we,
      input logic [11:0] ra, input logic [31:0] rwd, input logic err,
      input logic av, input logic [31:0] ard, input logic bv, input logic [31:0] brd);
    return {ag, bg, en, we, ra, rwd, err, av, ard, bv, brd};
  endfunction

  function automatic vec_t mk(
      input logic ar, input logic aw, input logic [31:0] aa, input logic [31:0] ad, input logic [3:0] as,
      input logic br, input logic bw, input logic [31:0] ba, input logic [31:0] bd, input logic [3:0] bs,
      input logic [OBS_W-1:0] e);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad; v.a_wstrb = as;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd; v.b_wstrb = bs;
    v.exp = e;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    a_req = v.a_req; a_we = v.a_we; a_addr = v.a_addr; a_wdata = v.a_wdata; a_wstrb = v.a_wstrb;
    b_req = v.b_req; b_we = v.b_we; b_addr = v.b_addr; b_wdata = v.b_wdata; b_wstrb = v.b_wstrb;
  endtask

  task automatic check(input string name, input logic [OBS_W-1:0] exp, input logic [OBS_W-1:0] mask);
    applied++;
    if ((act & mask) !== (exp & mask)) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (mask %h)", name, act, exp, mask);
    end
  endtask

  localparam logic [OBS_W-1:0] ALL = '1;
  // During reset only handshake, strobe and data outputs are constrained
  localparam logic [OBS_W-1:0] RST_MASK =
    {1'b1, 1'b1, 1'b1, 4'hF, 12'h0, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF};

  vec_t idle, ab_both, a_rd10;

  initial begin
    idle    = mk(0,0,0,0,0, 0,0,0,0,0, '0);
    ab_both = mk(1,0,32'h10,0,0, 1,0,32'h14,0,0, '0);
    a_rd10  = mk(1,0,32'h10,0,0, 0,0,0,0,0, '0);

    // rows: stimulus | a_gnt b_gnt en we addr wdata err a_rv a_rd b_rv b_rd
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,                          expv(0,0,0,0,0,0,0, 0,0, 0,0)));
    vecs.push_back(mk(1,0,32'h10,0,0, 0,0,0,0,0,                     expv(1,0,1,0,4,0,0, 0,0, 0,0)));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,                          expv(0,0,0,0,0,0,0, 1,D0, 0,0)));
    vecs.push_back(mk(0,0,0,0,0, 1,1,32'h8,32'h12345678,4'b0011,     expv(0,1,1,4'b0011,2,32'h12345678,0, 0,0, 0,0)));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,                          expv(0,0,0,0,0,0,0, 0,0, 0,0)));
    vecs.push_back(mk(0,0,0,0,0, 1,0,32'h8,0,0,                      expv(0,1,1,0,2,0,0, 0,0, 0,0)));
    vecs.push_back(mk(1,0,32'h14,0,0, 0,0,0,0,0,                     expv(1,0,1,0,5,0,0, 0,0, 1,32'h00005678)));
    vecs.push_back(mk(0,0,0,0,0, 1,0,32'h1C,0,0,                     expv(0,1,1,0,7,0,0, 1,D5, 0,0)));
    vecs.push_back(mk(1,0,32'h0001_0000,0,0, 0,0,0,0,0,              expv(1,0,0,0,0,0,1, 0,0, 1,D7)));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,                          expv(0,0,0,0,0,0,0, 1,0, 0,0)));
    vecs.push_back(mk(1,1,32'h4000,0,4'hF, 0,0,0,0,0,                expv(1,0,0,0,0,0,1, 0,0, 0,0)));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,                          expv(0,0,0,0,0,0,0, 0,0, 0,0)));
    // continuous contention: four A grants, then B forced through
    vecs.push_back(mk(1,0,32'h10,0,0, 1,0,32'h14,0,0,                expv(1,0,1,0,4,0,0, 0,0, 0,0)));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1,0,32'h10,0,0, 1,0,32'h14,0,0,              expv(1,0,1,0,4,0,0, 1,D0, 0,0)));
    vecs.push_back(mk(1,0,32'h10,0,0, 1,0,32'h14,0,0,                expv(0,1,1,0,5,0,0, 1,D0, 0,0)));
    vecs.push_back(mk(1,0,32'h10,0,0, 1,0,32'h14,0,0,                expv(1,0,1,0,4,0,0, 0,0, 1,D5)));
    vecs.push_back(mk(0,0,0,0,0, 1,0,32'h14,0,0,                     expv(0,1,1,0,5,0,0, 1,D0, 0,0)));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,                          expv(0,0,0,0,0,0,0, 0,0, 1,D5)));
    // counter must clear when B drops its request
    vecs.push_back(mk(1,0,32'h10,0,0, 1,0,32'h14,0,0,                expv(1,0,1,0,4,0,0, 0,0, 0,0)));
    vecs.push_back(mk(1,0,32'h10,0,0, 1,0,32'h14,0,0,                expv(1,0,1,0,4,0,0, 1,D0, 0,0)));
    vecs.push_back(mk(1,0,32'h10,0,0, 0,0,0,0,0,                     expv(1,0,1,0,4,0,0, 1,D0, 0,0)));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0,32'h10,0,0, 1,0,32'h14,0,0,              expv(1,0,1,0,4,0,0, 1,D0, 0,0)));
    vecs.push_back(mk(1,0,32'h10,0,0, 1,0,32'h14,0,0,                expv(0,1,1,0,5,0,0, 1,D0, 0,0)));
    vecs.push_back(mk(0,0,0,0,0, 0,0,0,0,0,                          expv(0,0,0,0,0,0,0, 0,0, 1,D5)));

    // reset with both ports requesting: everything quiet
    reset = 1'b1;
    drive(ab_both);
    #2;
    check("reset_state", '0, RST_MASK);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #2;
      check($sformatf("vec%0d", i), vecs[i].exp, ALL);
      @(negedge clk);
    end

    // saturate the starvation counter, leave a read in flight, then reset
    for (int i = 0; i < 4; i++) begin
      drive(ab_both);
      #2;
      check($sformatf("prestarve%0d", i), expv(1,0,1,0,4,0,0, (i != 0), (i != 0) ? D0 : 32'h0, 0,0), ALL);
      @(negedge clk);
    end
    reset = 1'b1;
    #2;
    check("reset_mid_read", '0, RST_MASK);
    @(negedge clk);
    reset = 1'b0;
    drive(idle);
    #2;
    check("rvalid_suppressed", '0, ALL);
    @(negedge clk);
    drive(ab_both);
    #2;
    check("counter_cleared", expv(1,0,1,0,4,0,0, 0,0, 0,0), ALL);
    @(negedge clk);
    drive(a_rd10);
    #2;
    check("post_reset_read", expv(1,0,1,0,4,0,0, 1,D0, 0,0), ALL);
    @(negedge clk);
    drive(idle);
    #2;
    check("post_reset_data", expv(0,0,0,0,0,0,0, 1,D0, 0,0), ALL);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, word-address width of the shared data RAM (4*2^ADDR_W bytes).
REQ-002 Parameter STARVE_LIMIT, default 4, consecutive denied cycles of port B before B is forced to win.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 a_req  input  1  port A (CPU data stage) request; held with its qualifiers until a_gnt.
REQ-006 a_we  input  1  port A write (1) / read (0).
REQ-007 a_addr  input  32  port A byte address.
REQ-008 a_wdata  input  32  port A write data.
REQ-009 a_wstrb  input  4  port A byte enables for writes.
REQ-010 a_gnt  output  1  port A request accepted this cycle.
REQ-011 a_rvalid  output  1  port A read data valid.
REQ-012 a_rdata  output  32  port A read data.
REQ-013 b_req, b_we, b_addr, b_wdata, b_wstrb, b_gnt, b_rvalid, b_rdata  same directions/widths/meanings as port A, for port B (UART loader/debug).
REQ-014 ram_en  output  1  RAM access strobe.
REQ-015 ram_we  output  4  RAM byte write enables.
REQ-016 ram_addr  output  ADDR_W  RAM word address.
REQ-017 ram_wdata  output  32  RAM write data.
REQ-018 ram_rdata  input  32  RAM read data, valid exactly one cycle after a read strobe.
REQ-019 addr_err  output  1  one-cycle pulse: granted access was out of range.

Function
REQ-020 Grant is combinational: at most one of a_gnt/b_gnt per cycle, asserted in the same cycle as the winning request.
REQ-021 Default priority: A wins when a_req=1, unless the starvation counter equals STARVE_LIMIT and b_req=1, in which case B wins.
REQ-022 Starvation counter (width clog2(STARVE_LIMIT+1)): increments on b_req && !b_gnt, saturates at STARVE_LIMIT, clears on b_gnt or b_req=0.
REQ-023 In range = address bits [31:ADDR_W+2] all zero; ram_addr = address[ADDR_W+1:2]; bits [1:0] ignored.
REQ-024 In-range grant: ram_en=1 same cycle; ram_we = wstrb if we=1, else 4'b0000; ram_wdata = winner wdata.
REQ-025 Out-of-range grant: ram_en=0, ram_we=0, addr_err=1 in the grant cycle; reads still return rvalid next cycle with rdata=0.
REQ-026 Read latency one cycle: 1-bit pending-owner register captures winner of a granted read; next cycle the owner's rvalid=1 and rdata = ram_rdata (0 if out of range).
REQ-027 Writes produce no rvalid.
REQ-028 Non-owner rdata = 0; rvalid never asserted on both ports at once.
REQ-029 Back-to-back: a new grant is permitted in the same cycle an earlier read's rvalid is returned; full throughput one access per cycle.
REQ-030 No request: ram_en=0, ram_we=0, ram_addr/ram_wdata = 0.
REQ-031 Simultaneous a_req and b_req with counter < STARVE_LIMIT: A wins, counter increments.

Reset
REQ-032 While reset=1: counter=0, read-pending cleared, a_gnt=b_gnt=a_rvalid=b_rvalid=addr_err=0, ram_en=0, ram_we=0, rdata outputs 0, regardless of requests.
REQ-033 Reset asserted between a read grant and its data cycle: that rvalid is suppressed.

Verification
REQ-034 A read 0x10 alone, RAM word 4 = 0xDEADBEEF -> a_gnt cycle 0, ram_addr=4, ram_en=1; a_rvalid=1, a_rdata=0xDEADBEEF cycle 1.
REQ-035 A and B request continuously, STARVE_LIMIT=4 -> A granted cycles 0-3, B granted cycle 4, counter 0 cycle 5, A granted cycle 5.
REQ-036 B write addr 0x8, wdata 0x12345678, wstrb 4'b0011, a_req=0 -> b_gnt=1, ram_we=4'b0011, ram_addr=2, no b_rvalid.
REQ-037 A read addr 0x0001_0000 (ADDR_W=12) -> a_gnt=1, ram_en=0, addr_err=1; next cycle a_rvalid=1, a_rdata=0.
REQ-038 A read granted, reset pulsed next cycle -> a_rvalid stays 0; all outputs 0 during reset.
REQ-039 Alternating A read then B read in consecutive cycles -> a_rvalid cycle 1, b_rvalid cycle 2, each with correct owner's data.
